// File: rtl/wptr_full_ctrl.sv
// rtl/wptr_full_ctrl.sv - write-side pointer, read-pointer synchronizer and full/level status for the async FIFO
module wptr_full_ctrl #(
    parameter int PTR_WIDTH    = 8,
    parameter int AFULL_THRESH = 4
) (
    input  logic                 w_clk,
    input  logic                 wrst,
    input  logic                 w_en,
    input  logic [PTR_WIDTH:0]   g_rptr,
    input  logic                 ovf_clr,
    output logic [PTR_WIDTH:0]   b_wptr,
    output logic [PTR_WIDTH:0]   g_wptr,
    output logic                 full,
    output logic                 almost_full,
    output logic [PTR_WIDTH:0]   w_level,
    output logic                 w_ack,
    output logic                 overflow
);

    localparam int W     = PTR_WIDTH + 1;
    localparam int DEPTH = 1 << PTR_WIDTH;
    localparam logic [PTR_WIDTH:0] AFULL_LEVEL = W'(DEPTH - AFULL_THRESH);

    logic [PTR_WIDTH:0] sync1;
    logic [PTR_WIDTH:0] g_rptr_sync;
    logic [PTR_WIDTH:0] b_rptr_sync;
    logic [PTR_WIDTH:0] b_wptr_next;
    logic [PTR_WIDTH:0] g_wptr_next;
    logic [PTR_WIDTH:0] level_next;
    logic               w_inc;
    logic               full_next;

    // A write is only accepted when the FIFO is not already full
    assign w_inc       = w_en & ~full;
    assign b_wptr_next = b_wptr + {{PTR_WIDTH{1'b0}}, w_inc};
    assign g_wptr_next = (b_wptr_next >> 1) ^ b_wptr_next;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
    always_comb begin
        b_rptr_sync = '0;
        for (int i = 0; i < W; i++) begin
            b_rptr_sync[i] = ^(g_rptr_sync >> i);
        end
    end

    // Full when the next write pointer equals the read pointer with the top two Gray bits inverted
    assign full_next  = (g_wptr_next == {~g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1],
                                         g_rptr_sync[PTR_WIDTH-2:0]});
    assign level_next = b_wptr_next - b_rptr_sync;

    // Two-flop synchronizer bringing the Gray read pointer into w_clk
    always_ff @(posedge w_clk) begin
        if (wrst) begin
            sync1       <= '0;
            g_rptr_sync <= '0;
        end else begin
            sync1       <= g_rptr;
            g_rptr_sync <= sync1;
        end
    end

    // Binary and Gray write pointers advance together on an accepted write
    always_ff @(posedge w_clk) begin
        if (wrst) begin
            b_wptr <= '0;
            g_wptr <= '0;
        end else begin
            b_wptr <= b_wptr_next;
            g_wptr <= g_wptr_next;
        end
    end

    // Registered status computed from next-state pointers
    always_ff @(posedge w_clk) begin
        if (wrst) begin
            full        <= 1'b0;
            almost_full <= 1'b0;
            w_level     <= '0;
            w_ack       <= 1'b0;
        end else begin
            full        <= full_next;
            almost_full <= (level_next >= AFULL_LEVEL);
            w_level     <= level_next;
            w_ack       <= w_inc;
        end
    end

    // Sticky overflow; a fresh overflow beats a simultaneous clear
    always_ff @(posedge w_clk) begin
        if (wrst) begin
            overflow <= 1'b0;
        end else if (w_en && full) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: doc/wptr_full_ctrl.md
Name: wptr_full_ctrl

Overview:
Write-domain pointer and status controller for the asynchronous FIFO; it is the write-side counterpart of the read-pointer/empty logic. It keeps the binary and Gray write pointers and brings the read-domain Gray pointer into w_clk through a 2-flop synchronizer. It produces registered full, almost-full, fill-level, write-acknowledge and sticky overflow status. b_wptr addresses the dual-port memory; g_wptr is synchronized into the read domain by the read side.

Parameters:
PTR_WIDTH, 8, address width; FIFO depth DEPTH = 2**PTR_WIDTH; pointers are PTR_WIDTH+1 bits. Legal range: PTR_WIDTH >= 2.
AFULL_THRESH, 4, almost_full asserts when free slots <= AFULL_THRESH. Legal range: 1..DEPTH-1.

Ports:
w_clk  input  1  write-domain clock; single clock for the whole block
wrst  input  1  synchronous, active-high reset
w_en  input  1  write request from the producer
g_rptr  input  PTR_WIDTH+1  Gray read pointer, asynchronous to w_clk
ovf_clr  input  1  clears the sticky overflow flag
b_wptr  output  PTR_WIDTH+1  binary write pointer (memory address = low PTR_WIDTH bits)
g_wptr  output  PTR_WIDTH+1  Gray write pointer, registered
full  output  1  FIFO full, registered
almost_full  output  1  free slots <= AFULL_THRESH, registered
w_level  output  PTR_WIDTH+1  occupancy as seen from the write domain, 0..DEPTH
w_ack  output  1  one-cycle pulse, the cycle after a write is accepted
overflow  output  1  sticky: a write was attempted while full

Behaviour:
- Reset: wrst is sampled on posedge w_clk only.
- Reset values: b_wptr=0, g_wptr=0, both sync stages=0, full=0, almost_full=0, w_level=0, w_ack=0, overflow=0. wrst overrides every other input.
- Reset mid-operation: all state clears at the next edge, including the synchronizer stages. No partial update occurs.
- Write accept: w_inc = w_en & ~full.
  - b_wptr_next = b_wptr + w_inc, modulo 2**(PTR_WIDTH+1).
  - g_wptr_next = (b_wptr_next >> 1) ^ b_wptr_next.
  - Both pointers register every edge.
- Synchronizer: g_rptr -> sync1 -> g_rptr_sync, one flop each edge. It must not feed combinational logic before the first flop.
- Gray-to-binary conversion: b_rptr_sync[MSB] = g_rptr_sync[MSB]; b_rptr_sync[i] = b_rptr_sync[i+1] ^ g_rptr_sync[i].
- full is registered from next-state values: full <= (g_wptr_next == {~g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1], g_rptr_sync[PTR_WIDTH-2:0]}).
- Level: level_next = b_wptr_next - b_rptr_sync, modulo 2**(PTR_WIDTH+1); w_level <= level_next.
- almost_full <= (level_next >= DEPTH - AFULL_THRESH). full implies almost_full.
- w_ack <= w_inc. A write is accepted at edge N; w_ack is high for the cycle following edge N.
- Overflow:
  - Set when w_en & full.
  - Clear when ovf_clr.
  - Set and clear in the same cycle: set wins, overflow stays 1.
  - Remains 1 until explicitly cleared.
- Full-side writes: a write while full is dropped. Pointers hold and w_ack=0.
- Latency: full/almost_full/w_level reflect a local write at the next edge. They reflect a read-side advance 3 w_clk edges after g_rptr changes (2 sync + 1 register). full is pessimistic and may stay high extra cycles, but never deasserts early.
- Wrap-around: pointers wrap from 2**(PTR_WIDTH+1)-1 to 0 with no special handling. The Gray sequence stays single-bit-change across the wrap.
- Empty/full ambiguity is resolved by the extra MSB: equal pointers = empty (level 0); MSB-differing = full (level DEPTH).

Test Plan:
1. Reset: hold wrst=1 for 2 cycles with w_en=1 and g_rptr=5'h1F -> b_wptr=0, g_wptr=0, full=0, w_level=0, w_ack=0, overflow=0 after the first edge.
2. Fill (PTR_WIDTH=3, AFULL_THRESH=2, g_rptr=0): 8 consecutive w_en cycles -> 8 w_ack pulses; almost_full rises with w_level=6; after the 8th write full=1, b_wptr=4'b1000, g_wptr=4'b1100, w_level=8.
3. Write while full (continuing from scenario 2): w_en=1 for 2 cycles -> b_wptr holds 4'b1000, w_ack=0, overflow=1 and stays 1. ovf_clr=1 with w_en=0 -> overflow=0 next edge. ovf_clr=1 with w_en=1 while full -> overflow stays 1.
4. Drain (from full): set g_rptr=4'b0001 (binary 1) -> full=0 and w_level=7 exactly 3 edges later. almost_full stays 1 until g_rptr=4'b0011 (binary 2) propagates, giving w_level=6 and free slots=2; almost_full then stays 1 because 2 <= AFULL_THRESH.
5. Wrap (PTR_WIDTH=3): g_rptr follows g_wptr with a 1-cycle lag; do 20 writes -> b_wptr passes 15->0 with g_wptr 4'b1000->4'b0000. full is never asserted and w_level stays <= 4.
6. Reset mid-operation: after 5 writes (b_wptr=5), pulse wrst=1 for 1 cycle with w_en=1 -> all outputs 0 at the next edge. The first write after reset gives b_wptr=1 and g_wptr=4'b0001.
